// File: rtl/start_disp_ctrl.sv
// rtl/start_disp_ctrl.sv - 640x480@60 VGA timing with a 200x200 start-picture window fed from a ROM stage
module start_disp_ctrl #(
    parameter int         PIC_X0   = 220,
    parameter int         PIC_Y0   = 140,
    parameter logic [7:0] BG_COLOR = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       disp_en,
    input  logic [7:0] start_data,
    output logic       start_rd_en,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic [7:0] vga_rgb,
    output logic       frame_start
);

    localparam logic [9:0] H_LAST   = 10'd799;
    localparam logic [9:0] V_LAST   = 10'd524;
    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] HS_FIRST = 10'd656;
    localparam logic [9:0] HS_LAST  = 10'd751;
    localparam logic [9:0] VS_FIRST = 10'd490;
    localparam logic [9:0] VS_LAST  = 10'd491;
    localparam logic [9:0] X_LO     = 10'(PIC_X0);
    localparam logic [9:0] X_HI     = 10'(PIC_X0 + 199);
    localparam logic [9:0] Y_LO     = 10'(PIC_Y0);
    localparam logic [9:0] Y_HI     = 10'(PIC_Y0 + 199);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       disp_en_q, disp_en_d;

    // Stage 1: flags decoded from the counters, one cycle behind them.
    // Sync flags are stored as "inside pulse" so an all-zero reset means idle.
    logic       win_s1_q, act_s1_q, hsp_s1_q, vsp_s1_q;

    // Stage 2: registered VGA outputs.
    logic       vga_hs_q, vga_vs_q;
    logic [7:0] vga_rgb_q;
    logic [7:0] rgb_d;

    logic       win, active, hs_pulse, vs_pulse;

    // Counter advance, frame-boundary enable sampling and window/sync decode
    always_comb begin
        h_cnt_d   = h_cnt_q + 10'd1;
        v_cnt_d   = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = 10'd0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end
        frame_start = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        disp_en_d   = frame_start ? disp_en : disp_en_q;
        win         = (h_cnt_q >= X_LO) && (h_cnt_q <= X_HI) &&
                      (v_cnt_q >= Y_LO) && (v_cnt_q <= Y_HI);
        active      = (h_cnt_q < H_ACTIVE) && (v_cnt_q < V_ACTIVE);
        hs_pulse    = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
        vs_pulse    = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
        start_rd_en = win && disp_en_q;
    end

    // Pixel select for stage 2: ROM data arrives alongside the stage-1 window flag
    always_comb begin
        rgb_d = 8'h00;
        if (win_s1_q && disp_en_q) begin
            rgb_d = start_data;
        end else if (act_s1_q) begin
            rgb_d = BG_COLOR;
        end
    end

    // Free-running counters and the per-frame enable latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q   <= 10'd0;
            v_cnt_q   <= 10'd0;
            disp_en_q <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            disp_en_q <= disp_en_d;
        end
    end

    // Two-stage output pipeline: decode flags, then registered VGA outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_s1_q  <= 1'b0;
            act_s1_q  <= 1'b0;
            hsp_s1_q  <= 1'b0;
            vsp_s1_q  <= 1'b0;
            vga_hs_q  <= 1'b1;
            vga_vs_q  <= 1'b1;
            vga_rgb_q <= 8'h00;
        end else begin
            win_s1_q  <= win;
            act_s1_q  <= active;
            hsp_s1_q  <= hs_pulse;
            vsp_s1_q  <= vs_pulse;
            vga_hs_q  <= ~hsp_s1_q;
            vga_vs_q  <= ~vsp_s1_q;
            vga_rgb_q <= rgb_d;
        end
    end

    assign vga_hs  = vga_hs_q;
    assign vga_vs  = vga_vs_q;
    assign vga_rgb = vga_rgb_q;

endmodule
